rr_stream_arbiter: RTL and testbench
====================================

Name: rr_stream_arbiter

Overview:
- Round-robin arbiter with a valid/ready handshake that sits directly upstream of the team's channel multiplexor.
- Selects one of CH_NUM requesting input streams and drives the channel index as a registered address output (out_addr), which feeds the multiplexor's addr input. Also registers the selected data word.
- Turns a combinational channel select into a fair, back-pressured, one-beat-per-cycle stream merge.

Parameters:
- DWIDTH, 8: data width per channel in bits.
- CH_NUM, 3: number of input channels; legal range 2 or more, so that $clog2(CH_NUM) is at least 1.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  [CH_NUM-1:0][DWIDTH-1:0]  per-channel data, packed channel-major.
- in_valid  input  [CH_NUM-1:0]  per-channel data valid.
- in_ready  output  [CH_NUM-1:0]  per-channel accept; at most one bit high.
- out_data  output  [DWIDTH-1:0]  registered selected data.
- out_addr  output  [$clog2(CH_NUM)-1:0]  registered index of the channel that produced out_data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Interface decision: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset state:
  - out_valid=0, out_data=0, out_addr=0.
  - Priority pointer last_grant=CH_NUM-1, so channel 0 has top priority after reset.
  - in_ready is all zeros while rst is high.
- Reset mid-operation: out_valid clears asynchronously and any held beat is discarded. In packet-lock builds, the lock also clears.
- Load condition: load = ~out_valid | out_ready. The output register can accept a new beat this cycle.
- Grant selection is combinational:
  - Scan channels (last_grant+1) mod CH_NUM, (last_grant+2) mod CH_NUM, and so on, ending at last_grant.
  - The first channel with in_valid=1 is granted (g).
  - Wrap-around is modulo CH_NUM, not modulo 2^$clog2(CH_NUM). Example: CH_NUM=3 with last_grant=2 wraps to 0.
- in_ready[g] = load & in_valid[g]. All other in_ready bits are 0.
  - in_ready depends on in_valid. Upstream must not make in_valid depend on in_ready.
- Transfer on channel g (in_valid[g] & in_ready[g]), at the next clock edge:
  - out_data <= in_data[g], out_addr <= g, out_valid <= 1, last_grant <= g.
- load=1 and no channel valid: out_valid <= 0 if out_ready was high; otherwise unchanged. last_grant is unchanged.
- Stall (out_valid=1, out_ready=0):
  - out_data, out_addr and out_valid are held stable.
  - All in_ready bits are 0.
- Simultaneous drain and refill (out_valid=1, out_ready=1, some in_valid=1): the new beat loads in the same cycle.
  - Full throughput is one beat per clock with no bubble.
- Latency: one clock from input transfer to out_valid.
- Fairness: with all channels continuously valid, grants rotate 0,1,...,CH_NUM-1,0,...
- Out-of-range pointer: last_grant is only ever loaded with legal values 0..CH_NUM-1.
- Internal arithmetic: the pointer increment is computed with one extra bit before the modulo compare.

Optional Feature:
- Macro: RR_STREAM_ARBITER_PKT_LOCK_EN.
- Defined:
  - Adds input port in_last [CH_NUM-1:0] and output port out_last (1 bit, registered with out_data, reset 0).
  - Two-state FSM: ARB and LOCK.
  - ARB: arbitrate as above. A transfer with in_last[g]=0 moves to LOCK with the grant frozen to g.
  - LOCK: only channel g may get in_ready; other channels' in_valid is ignored. A transfer with in_last[g]=1 returns to ARB and sets last_grant <= g.
  - Single-beat packets (in_last=1 on the first beat) stay in ARB.
- Undefined: no in_last or out_last ports and no FSM. Every beat is arbitrated independently.

Test Plan:
- Reset then idle: after rst release, all in_valid=0 -> out_valid=0, in_ready=3'b000, out_addr=0, out_data=0.
- Single request: in_valid=3'b010, in_data[1]=8'hA5, out_ready=1 -> in_ready=3'b010. Next cycle out_valid=1, out_data=8'hA5, out_addr=1.
- Full contention: in_valid=3'b111 for 6 cycles, out_ready=1, in_data[i]=8'h10+i.
  - Expected out_addr sequence 0,1,2,0,1,2 with matching out_data 8'h10,8'h11,8'h12,...
  - out_valid continuous with no bubbles.
- Back-pressure: out_ready=0 for 3 cycles while out_valid=1 holding 8'h11/addr 1.
  - out_data and out_addr stay stable; in_ready=0.
  - On out_ready=1, the next grant is channel 2.
- Asynchronous reset mid-stream: assert rst between clock edges while out_valid=1.
  - out_valid falls immediately.
  - After release, the first grant with in_valid=3'b111 goes to channel 0.
- PKT_LOCK build: channel 2 sends a 3-beat packet (in_last on beat 3) while channels 0 and 1 are valid.
  - out_addr = 2,2,2 with out_last on the third beat only.
  - The next grant is channel 0.

Source files
------------

// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin merge of CH_NUM valid/ready streams into a
// single registered output beat (data plus source channel index).
// Optional packet lock: define RR_STREAM_ARBITER_PKT_LOCK_EN to add in_last /
// out_last and hold the grant on one channel until its last beat transfers.
module rr_stream_arbiter #(
  parameter int DWIDTH = 8,
  parameter int CH_NUM = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CH_NUM-1:0][DWIDTH-1:0]  in_data,
  input  logic [CH_NUM-1:0]              in_valid,
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
  input  logic [CH_NUM-1:0]              in_last,
`endif
  output logic [CH_NUM-1:0]              in_ready,
  output logic [DWIDTH-1:0]              out_data,
  output logic [$clog2(CH_NUM)-1:0]      out_addr,
  output logic                           out_valid,
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
  output logic                           out_last,
`endif
  input  logic                           out_ready
);

  localparam int AW = $clog2(CH_NUM);
  localparam logic [AW:0]   CH_NUM_EXT = (AW+1)'(CH_NUM);
  localparam logic [AW-1:0] LAST_CH    = AW'(CH_NUM - 1);

  logic [DWIDTH-1:0] out_data_r;
  logic [AW-1:0]     out_addr_r;
  logic              out_valid_r;
  logic [AW-1:0]     last_grant_r;

  logic [AW-1:0]     scan_ptr_s;
  logic [AW:0]       scan_ext_s;
  logic [AW-1:0]     rr_grant_s;
  logic              rr_found_s;
  logic [AW-1:0]     sel_s;
  logic              sel_valid_s;
  logic              load_s;
  logic              xfer_s;
  logic [CH_NUM-1:0] in_ready_s;

  // Round-robin scan starting just after last_grant, wrapping modulo CH_NUM.
  always_comb begin
    rr_found_s = 1'b0;
    rr_grant_s = '0;
    scan_ptr_s = last_grant_r;
    scan_ext_s = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      scan_ext_s = {1'b0, scan_ptr_s} + (AW+1)'(1);
      if (scan_ext_s == CH_NUM_EXT) begin
        scan_ptr_s = '0;
      end else begin
        scan_ptr_s = scan_ext_s[AW-1:0];
      end
      if (!rr_found_s && in_valid[scan_ptr_s]) begin
        rr_found_s = 1'b1;
        rr_grant_s = scan_ptr_s;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;
  state_t        state_r, state_s;
  logic [AW-1:0] lock_ch_r;
  logic          out_last_r;

  // Channel selection: free arbitration in ARB, frozen channel in LOCK.
  always_comb begin
    sel_s       = rr_grant_s;
    sel_valid_s = rr_found_s;
    case (state_r)
      ST_ARB: begin
        sel_s       = rr_grant_s;
        sel_valid_s = rr_found_s;
      end
      ST_LOCK: begin
        sel_s       = lock_ch_r;
        sel_valid_s = in_valid[lock_ch_r];
      end
      default: begin
        sel_s       = rr_grant_s;
        sel_valid_s = rr_found_s;
      end
    endcase
  end

  // Next state: enter LOCK on a non-last beat, leave it on the last beat.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_ARB: begin
        if (xfer_s && !in_last[sel_s]) state_s = ST_LOCK;
        else                           state_s = ST_ARB;
      end
      ST_LOCK: begin
        if (xfer_s && in_last[sel_s]) state_s = ST_ARB;
        else                          state_s = ST_LOCK;
      end
      default: state_s = ST_ARB;
    endcase
  end

  // FSM state, locked channel and the last flag that travels with out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_ARB;
      lock_ch_r  <= '0;
      out_last_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (xfer_s) begin
        lock_ch_r  <= sel_s;
        out_last_r <= in_last[sel_s];
      end else begin
        lock_ch_r  <= lock_ch_r;
        out_last_r <= out_last_r;
      end
    end
  end

  assign out_last = out_last_r;
`else
  // Without packet lock every beat is arbitrated independently.
  always_comb begin
    sel_s       = rr_grant_s;
    sel_valid_s = rr_found_s;
  end
`endif

  assign load_s = ~out_valid_r | out_ready;
  assign xfer_s = load_s & sel_valid_s;

  // Accept only the selected channel, and never while reset is asserted.
  always_comb begin
    in_ready_s = '0;
    if (!rst && xfer_s) begin
      in_ready_s[sel_s] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
  end

  // Output register and priority pointer; refill in the same cycle as drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_addr_r   <= '0;
      last_grant_r <= LAST_CH;
    end else if (xfer_s) begin
      out_valid_r  <= 1'b1;
      out_data_r   <= in_data[sel_s];
      out_addr_r   <= sel_s;
      last_grant_r <= sel_s;
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_addr  = out_addr_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed testbench for rr_stream_arbiter (DWIDTH=8, CH_NUM=3).
module tb_rr_stream_arbiter;

  logic             clk;
  logic             rst;
  logic [2:0][7:0]  in_data;
  logic [2:0]       in_valid;
  logic [2:0]       in_ready;
  logic [7:0]       out_data;
  logic [1:0]       out_addr;
  logic             out_valid;
  logic             out_ready;
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
  logic [2:0]       in_last;
  logic             out_last;
`endif

  int checks;
  int fails;

  rr_stream_arbiter #(.DWIDTH(8), .CH_NUM(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
    .out_last  (out_last),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid  = 3'b000;
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 3'b111;
    out_ready = 1'b1;
    in_data   = {8'h12, 8'h11, 8'h10};
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
    in_last   = 3'b111;
`endif
    #3;
    checks++;
    if (in_ready !== 3'b000) begin fails++; $display("FAIL reset_in_ready: got %b want 000", in_ready); end
    tick();
    in_valid = 3'b000;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 3'b000) begin fails++; $display("FAIL idle_in_ready: got %b want 000", in_ready); end
    checks++;
    if (out_addr !== 2'd0) begin fails++; $display("FAIL idle_out_addr: got %0d want 0", out_addr); end
    checks++;
    if (out_data !== 8'h00) begin fails++; $display("FAIL idle_out_data: got %h want 00", out_data); end
  endtask

  task automatic test_single();
    in_valid   = 3'b010;
    in_data[1] = 8'hA5;
    out_ready  = 1'b1;
    #1;
    checks++;
    if (in_ready !== 3'b010) begin fails++; $display("FAIL single_in_ready: got %b want 010", in_ready); end
    tick();
    in_valid = 3'b000;
    checks++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
    checks++;
    if (out_data !== 8'hA5) begin fails++; $display("FAIL single_out_data: got %h want a5", out_data); end
    checks++;
    if (out_addr !== 2'd1) begin fails++; $display("FAIL single_out_addr: got %0d want 1", out_addr); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_addr;
    logic [7:0] exp_data;
    apply_reset();
    in_data   = {8'h12, 8'h11, 8'h10};
    in_valid  = 3'b111;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_addr = 2'(i % 3);
      exp_data = 8'h10 + 8'(i % 3);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_addr !== exp_addr || out_data !== exp_data) begin
        fails++;
        $display("FAIL contention_beat%0d: got v=%b a=%0d d=%h want v=1 a=%0d d=%h",
                 i, out_valid, out_addr, out_data, exp_addr, exp_data);
      end
    end
    in_valid = 3'b000;
    tick();
  endtask

  task automatic test_back_pressure();
    apply_reset();
    in_data   = {8'h12, 8'h11, 8'h10};
    in_valid  = 3'b111;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_data !== 8'h11 || out_addr !== 2'd1) begin
      fails++; $display("FAIL bp_hold_start: got a=%0d d=%h want a=1 d=11", out_addr, out_data);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 3'b000) begin fails++; $display("FAIL bp_in_ready%0d: got %b want 000", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || out_addr !== 2'd1) begin
        fails++;
        $display("FAIL bp_stall%0d: got v=%b a=%0d d=%h want v=1 a=1 d=11", i, out_valid, out_addr, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 3'b100) begin fails++; $display("FAIL bp_release_ready: got %b want 100", in_ready); end
    tick();
    checks++;
    if (out_addr !== 2'd2 || out_data !== 8'h12) begin
      fails++; $display("FAIL bp_next_grant: got a=%0d d=%h want a=2 d=12", out_addr, out_data);
    end
    in_valid = 3'b000;
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    in_data   = {8'h12, 8'h11, 8'h10};
    in_valid  = 3'b111;
    out_ready = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL async_rst_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 3'b000) begin fails++; $display("FAIL async_rst_ready: got %b want 000", in_ready); end
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 3'b001) begin fails++; $display("FAIL async_first_ready: got %b want 001", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 2'd0 || out_data !== 8'h10) begin
      fails++;
      $display("FAIL async_first_grant: got v=%b a=%0d d=%h want v=1 a=0 d=10", out_valid, out_addr, out_data);
    end
    in_valid = 3'b000;
    tick();
  endtask

`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
  task automatic test_pkt_lock();
    logic [1:0] exp_addr [6];
    logic       exp_last [6];
    exp_addr = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
    exp_last = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    in_valid  = 3'b111;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = {8'h20 + 8'(k), 8'h11, 8'h10};
      in_last = (k >= 4) ? 3'b111 : 3'b011;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_addr !== exp_addr[k] || out_last !== exp_last[k]) begin
        fails++;
        $display("FAIL pkt_lock_beat%0d: got v=%b a=%0d l=%b want v=1 a=%0d l=%b",
                 k, out_valid, out_addr, out_last, exp_addr[k], exp_last[k]);
      end
    end
    in_valid = 3'b000;
    tick();
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_async_reset();
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
